// File: rtl/md_alu_seq.sv
// md_alu_seq: multi-cycle 32x32 multiply / 32/32 divide sequenced through the shared ALU.
// Define SIGNED_MD_EN for signed MULT/DIV (op[1]) using magnitude operands and a sign-fix state.
module md_alu_seq #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] MD_A,
  input  logic [XLEN-1:0] MD_B,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            alu_req,
  output logic [XLEN-1:0] ALU_DA,
  output logic [XLEN-1:0] ALU_DB,
  output logic [3:0]      ALU_CTL,
  input  logic [XLEN-1:0] ALU_DC
);
`ifdef SIGNED_MD_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam logic [3:0] CTL_ADD = 4'b0000, CTL_SUB = 4'b0010, CTL_LTU = 4'b1000;
  typedef enum logic [2:0] {IDLE, PH_A, PH_B, FIX, DONE} state_t;
  state_t state, state_d;
  logic [ITER_W-1:0] cnt;
  logic [XLEN-1:0] opr, sum_q, opb_q, r_sh, a_mag, b_mag;
  logic is_div, msb_q, lt_q, sa, sb, a_neg, b_neg, accept, div0, ge;
  always_comb begin
    a_neg   = SGN & op[1] & MD_A[XLEN-1];
    b_neg   = SGN & op[1] & MD_B[XLEN-1];
    a_mag   = a_neg ? -MD_A : MD_A;
    b_mag   = b_neg ? -MD_B : MD_B;
    accept  = state == IDLE && start && !flush;
    div0    = op[0] && MD_B == '0;
    r_sh    = {HI[XLEN-2:0], LO[XLEN-1]};
    ge      = msb_q | ~lt_q;
    busy    = state inside {PH_A, PH_B, FIX};
    alu_req = busy;
    done    = state == DONE;
    ALU_DA  = state == PH_A ? (is_div ? r_sh : HI) : state == PH_B ? sum_q : '0;
    ALU_DB  = state == PH_A ? ((is_div || LO[0]) ? opr : '0) : state == PH_B ? opb_q : '0;
    ALU_CTL = state == PH_A ? (is_div ? CTL_LTU : CTL_ADD) :
              state == PH_B ? (is_div ? CTL_SUB : CTL_LTU) : CTL_ADD;
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? (div0 ? DONE : PH_A) : IDLE;
      PH_A:    state_d = PH_B;
      PH_B:    state_d = cnt == ITER_W'(XLEN-1) ? (SGN ? FIX : DONE) : PH_A;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  // flush freezes the datapath so HI/LO keep whatever partial result they hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      HI       <= '0;
      LO       <= '0;
      opr      <= '0;
      sum_q    <= '0;
      opb_q    <= '0;
      is_div   <= 1'b0;
      msb_q    <= 1'b0;
      lt_q     <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt      <= '0;
        is_div   <= op[0];
        div_zero <= div0;
        sa       <= a_neg;
        sb       <= b_neg;
        opr      <= op[0] ? b_mag : a_mag;
        HI       <= div0 ? MD_A : '0;
        LO       <= div0 ? '1 : (op[0] ? a_mag : b_mag);
      end else if (!flush && state == PH_A) begin
        sum_q <= is_div ? r_sh : ALU_DC;
        opb_q <= ALU_DB;
        msb_q <= HI[XLEN-1];
        lt_q  <= ALU_DC[0];
      end else if (!flush && state == PH_B) begin
        cnt <= cnt + ITER_W'(1);
        if (is_div) begin
          HI <= ge ? ALU_DC : sum_q;
          LO <= {LO[XLEN-2:0], ge};
        end else
          {HI, LO} <= {ALU_DC[0], sum_q, LO[XLEN-1:1]};
      end else if (!flush && state == FIX) begin
        if (is_div) begin
          LO <= (sa ^ sb) ? -LO : LO;
          HI <= sa ? -HI : HI;
        end else if (sa ^ sb)
          {HI, LO} <= -{HI, LO};
      end
    end
endmodule

// File: tb/tb_md_alu_seq.sv
// tb_md_alu_seq: directed and random self-checking bench for md_alu_seq with a behavioural ALU.
module tb_md_alu_seq;
`ifdef SIGNED_MD_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam int LAT = SGN ? 66 : 65;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] md_a = '0, md_b = '0, alu_dc;
  logic busy, done, div_zero, alu_req;
  logic [31:0] hi, lo, alu_da, alu_db;
  logic [3:0] alu_ctl;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  md_alu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
    .MD_A(md_a), .MD_B(md_b), .busy(busy), .done(done), .div_zero(div_zero),
    .HI(hi), .LO(lo), .alu_req(alu_req), .ALU_DA(alu_da), .ALU_DB(alu_db),
    .ALU_CTL(alu_ctl), .ALU_DC(alu_dc)
  );
  always_comb
    case (alu_ctl)
      4'b0000: alu_dc = alu_da + alu_db;
      4'b0010: alu_dc = alu_da - alu_db;
      4'b1000: alu_dc = {31'b0, alu_da < alu_db};
      default: alu_dc = '0;
    endcase

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output int lat, output bit req_ok);
    @(negedge clk);
    while (done) @(negedge clk);
    op = o; md_a = a; md_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; req_ok = 1'b1;
    while (!done && lat < 200) begin
      if (!alu_req) req_ok = 1'b0;
      if (lat == poke) begin start = 1'b1; op = 2'b01; md_a = 32'd100; md_b = 32'd0; end
      if (lat == poke + 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, div_zero, alu_req} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, alu_req}); else passed++;
    total++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passed++;
    total++; if ({alu_da, alu_db, alu_ctl} !== 68'd0) $display("FAIL reset_alu: got %h want 0", {alu_da, alu_db, alu_ctl}); else passed++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_multu;
    int lat; bit ok;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, ok);
    total++; if (lat !== LAT) $display("FAIL multu_latency: got %0d want %0d", lat, LAT); else passed++;
    total++; if (ok !== 1'b1) $display("FAIL multu_alu_req: got %b want 1", ok); else passed++;
    total++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want FFFFFFFE", hi); else passed++;
    total++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", lo); else passed++;
    total++; if ({busy, div_zero} !== 2'b00) $display("FAIL multu_done_flags: got %b want 00", {busy, div_zero}); else passed++;
    total++; if (alu_ctl !== 4'b0000 || alu_da !== 32'd0) $display("FAIL multu_alu_idle: got %h/%h want 0/0", alu_ctl, alu_da); else passed++;
  endtask

  task automatic test_divu;
    int lat; bit ok;
    run_op(2'b01, 32'd100, 32'd7, 0, lat, ok);
    total++; if (lat !== LAT) $display("FAIL divu_latency: got %0d want %0d", lat, LAT); else passed++;
    total++; if ({lo, hi, div_zero} !== {32'd14, 32'd2, 1'b0}) $display("FAIL divu_100_7: got %h %h %b want 0000000e 00000002 0", lo, hi, div_zero); else passed++;
    run_op(2'b01, 32'd5, 32'h80000001, 0, lat, ok);
    total++; if ({lo, hi} !== {32'd0, 32'd5}) $display("FAIL divu_small: got %h %h want 00000000 00000005", lo, hi); else passed++;
    run_op(2'b01, 32'hFFFFFFFF, 32'd1, 0, lat, ok);
    total++; if ({lo, hi} !== {32'hFFFFFFFF, 32'd0}) $display("FAIL divu_msb: got %h %h want ffffffff 00000000", lo, hi); else passed++;
    run_op(2'b01, 32'hFFFFFFFF, 32'h80000000, 0, lat, ok);
    total++; if ({lo, hi} !== {32'd1, 32'h7FFFFFFF}) $display("FAIL divu_big: got %h %h want 00000001 7fffffff", lo, hi); else passed++;
  endtask

  task automatic test_div_zero;
    int lat; bit ok;
    run_op(2'b01, 32'h1234, 32'd0, 0, lat, ok);
    total++; if (lat !== 1) $display("FAIL div0_latency: got %0d want 1", lat); else passed++;
    total++; if ({lo, hi} !== {32'hFFFFFFFF, 32'h1234}) $display("FAIL div0_result: got %h %h want ffffffff 00001234", lo, hi); else passed++;
    total++; if ({div_zero, busy} !== 2'b10) $display("FAIL div0_flags: got %b want 10", {div_zero, busy}); else passed++;
    @(posedge clk); #1;
    total++; if ({done, busy, div_zero} !== 3'b001) $display("FAIL div0_after: got %b want 001", {done, busy, div_zero}); else passed++;
  endtask

  task automatic test_start_ignored;
    int lat; bit ok;
    run_op(2'b00, 32'd3, 32'd5, 10, lat, ok);
    total++; if (lat !== LAT) $display("FAIL ignored_latency: got %0d want %0d", lat, LAT); else passed++;
    total++; if ({hi, lo} !== 64'd15) $display("FAIL ignored_result: got %h want 15", {hi, lo}); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL div_zero_clear: got %b want 0", div_zero); else passed++;
  endtask

  task automatic test_flush;
    int lat; bit seen;
    logic [63:0] part;
    part = ((64'hFFFFFFFF * 64'h3FF) << 22) | (64'hFFFFFFFF >> 10);
    @(negedge clk);
    while (done) @(negedge clk);
    op = 2'b00; md_a = 32'hFFFFFFFF; md_b = 32'hFFFFFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (lat < 21) begin @(posedge clk); #1; lat++; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    total++; if ({busy, alu_req, done} !== 3'b000) $display("FAIL flush_idle: got %b want 000", {busy, alu_req, done}); else passed++;
    total++; if ({hi, lo} !== part) $display("FAIL flush_partial: got %h want %h", {hi, lo}, part); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("FAIL flush_no_done: got %b want 0", seen); else passed++;
    @(negedge clk); flush = 1'b1; start = 1'b1; md_a = 32'd3; md_b = 32'd5;
    @(posedge clk); #1; flush = 1'b0; start = 1'b0;
    total++; if ({busy, done} !== 2'b00 || {hi, lo} !== part) $display("FAIL flush_beats_start: got %b %h want 00 %h", {busy, done}, {hi, lo}, part); else passed++;
  endtask

  task automatic test_async_reset;
    int lat; bit ok;
    @(negedge clk);
    op = 2'b01; md_a = 32'hFFFFFFFF; md_b = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    total++; if ({busy, done, div_zero, alu_req} !== 4'b0) $display("FAIL areset_flags: got %b want 0000", {busy, done, div_zero, alu_req}); else passed++;
    total++; if ({hi, lo} !== 64'd0) $display("FAIL areset_hilo: got %h want 0", {hi, lo}); else passed++;
    total++; if ({alu_da, alu_db, alu_ctl} !== 68'd0) $display("FAIL areset_alu: got %h want 0", {alu_da, alu_db, alu_ctl}); else passed++;
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b00, 32'd3, 32'd5, 0, lat, ok);
    total++; if ({hi, lo} !== 64'd15 || lat !== LAT) $display("FAIL post_reset_mul: got %h lat %0d want 15 lat %0d", {hi, lo}, lat, LAT); else passed++;
  endtask

  task automatic test_signed;
    int lat; bit ok;
`ifdef SIGNED_MD_EN
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, 0, lat, ok);
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) $display("FAIL mult_neg: got %h want ffffffffffffff1", {hi, lo}); else passed++;
    total++; if (lat !== 66) $display("FAIL mult_latency: got %0d want 66", lat); else passed++;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, lat, ok);
    total++; if ({lo, hi} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) $display("FAIL div_neg_a: got %h %h want fffffffd ffffffff", lo, hi); else passed++;
    run_op(2'b11, 32'd7, 32'hFFFFFFFE, 0, lat, ok);
    total++; if ({lo, hi} !== {32'hFFFFFFFD, 32'd1}) $display("FAIL div_neg_b: got %h %h want fffffffd 00000001", lo, hi); else passed++;
    run_op(2'b11, 32'hFFFFFFF9, 32'd0, 0, lat, ok);
    total++; if ({lo, hi, div_zero} !== {32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1} || lat !== 1) $display("FAIL div_signed_zero: got %h %h %b lat %0d want ffffffff fffffff9 1 lat 1", lo, hi, div_zero, lat); else passed++;
`else
    run_op(2'b10, 32'hFFFFFFFD, 32'd5, 0, lat, ok);
    total++; if ({hi, lo} !== 64'h00000004_FFFFFFF1 || lat !== 65) $display("FAIL op1_ignored_mul: got %h lat %0d want 4fffffff1 lat 65", {hi, lo}, lat); else passed++;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, lat, ok);
    total++; if ({lo, hi} !== {32'h7FFFFFFC, 32'd1}) $display("FAIL op1_ignored_div: got %h %h want 7ffffffc 00000001", lo, hi); else passed++;
`endif
  endtask

  task automatic test_random;
    int lat; bit ok;
    logic [31:0] a, b, eh, el;
    logic ez;
    logic [63:0] p;
    int elat;
    for (int o = 0; o < (SGN ? 4 : 2); o++)
      for (int n = 0; n < 100; n++) begin
        a = $urandom;
        b = (n % 8 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        if (n % 16 == 3) a = 32'h80000000;
        if (n % 16 == 5) b = 32'hFFFFFFFF;
        run_op(o[1:0], a, b, 0, lat, ok);
        ez = 1'b0;
        elat = LAT;
        if (o == 0) p = {32'd0, a} * {32'd0, b};
        else if (o == 2) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else if (b == 0) begin p = {a, 32'hFFFFFFFF}; ez = 1'b1; elat = 1; end
        else if (o == 1) p = {a % b, a / b};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
        else p = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        {eh, el} = p;
        total++;
        if ({hi, lo, div_zero} !== {eh, el, ez} || lat !== elat)
          $display("FAIL random_op%0d a=%h b=%h: got %h %h %b lat %0d want %h %h %b lat %0d", o, a, b, hi, lo, div_zero, lat, eh, el, ez, elat);
        else passed++;
      end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_divu();
    test_div_zero();
    test_start_ignored();
    test_flush();
    test_async_reset();
    test_signed();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
